// File: rtl/arb_req_agent_16.sv
// Requester-side agent for the 16-port arbiter: per-port token queues,
// req/grant burst handshake, serialized beat stream. Option: ARB_REQ_TIMEOUT_EN.
module arb_req_agent_16 #(
  parameter int BEAT_LEN = 4,
  parameter int MAX_PEND = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] push,
  output logic [15:0] pend_full,
  output logic [15:0] req,
  input  logic [15:0] grant,
  output logic        xfer_vld,
  output logic [3:0]  xfer_port,
  output logic        xfer_last,
  output logic        err_grant,
  output logic [15:0] starve
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL
  } st_t;

  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);
  localparam logic [3:0] LAST_IDX = 4'(BEAT_LEN - 1);
  localparam bit         ONE_BEAT = (BEAT_LEN == 1);

  st_t         state_q [16];
  logic [3:0]  pend_q  [16];
  logic [3:0]  bcnt_q  [16];
  logic [15:0] req_q;

  logic        multi_hot;
  logic        bad_port;
  logic        illegal;
  logic [15:0] beat;
  logic [15:0] last;
  logic [3:0]  beat_idx;
  logic [3:0]  pend_nx [16];

  assign req = req_q;

  // req_q is high exactly in REQ/XFER, so it doubles as the grantable mask
  always_comb begin
    multi_hot = (grant & (grant - 16'd1)) != 16'd0;
    bad_port  = |(grant & ~req_q);
    illegal   = multi_hot | bad_port;
    beat      = '0;
    last      = '0;
    beat_idx  = '0;
    pend_full = '0;
    for (int i = 0; i < 16; i++) begin
      beat[i] = grant[i] & ~illegal;
      last[i] = beat[i] &
                ((state_q[i] == S_REQ && ONE_BEAT) ||
                 (state_q[i] == S_XFER && bcnt_q[i] == LAST_IDX));
      if (beat[i])
        beat_idx = 4'(i);
      pend_nx[i] = pend_q[i];
      if (last[i])
        pend_nx[i] = push[i] ? pend_q[i] : pend_q[i] - 4'd1;
      else if (push[i] && pend_q[i] != PEND_MAX)
        pend_nx[i] = pend_q[i] + 4'd1;
      pend_full[i] = (pend_q[i] == PEND_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        state_q[i] <= S_IDLE;
        pend_q[i]  <= '0;
        bcnt_q[i]  <= '0;
      end
      req_q     <= '0;
      xfer_vld  <= 1'b0;
      xfer_port <= '0;
      xfer_last <= 1'b0;
      err_grant <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        pend_q[i] <= pend_nx[i];
        unique case (state_q[i])
          S_IDLE: begin
            if (pend_nx[i] != 4'd0) begin
              state_q[i] <= S_REQ;
              req_q[i]   <= 1'b1;
            end
          end
          S_REQ: begin
            if (beat[i]) begin
              if (ONE_BEAT) begin
                state_q[i] <= S_REL;
                req_q[i]   <= 1'b0;
              end else begin
                state_q[i] <= S_XFER;
                bcnt_q[i]  <= 4'd1;
              end
            end
          end
          S_XFER: begin
            if (last[i]) begin
              state_q[i] <= S_REL;
              req_q[i]   <= 1'b0;
              bcnt_q[i]  <= 4'd0;
            end else if (beat[i]) begin
              bcnt_q[i] <= bcnt_q[i] + 4'd1;
            end
          end
          S_REL: begin
            if (pend_nx[i] != 4'd0) begin
              state_q[i] <= S_REQ;
              req_q[i]   <= 1'b1;
            end else begin
              state_q[i] <= S_IDLE;
            end
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
      xfer_vld  <= |beat;
      err_grant <= illegal;
      if (|beat) begin
        xfer_port <= beat_idx;
        xfer_last <= |last;
      end
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  logic [7:0]  wait_q [16];
  logic [15:0] starve_q;

  assign starve = starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        wait_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (beat[i]) begin
          wait_q[i]   <= '0;
          starve_q[i] <= 1'b0;
        end else if (state_q[i] == S_REQ && !grant[i] &&
                     wait_q[i] != 8'hFF) begin
          wait_q[i] <= wait_q[i] + 8'd1;
          if (wait_q[i] + 8'd1 == 8'(TIMEOUT))
            starve_q[i] <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign starve = '0;
`endif

endmodule

// File: tb/tb_arb_req_agent_16.sv
// Self-checking bench for arb_req_agent_16: vector table, directed
// corner sequences and randomized traffic against a burst-level model.
module tb_arb_req_agent_16;

  localparam int BL   = 4;
  localparam int MAXP = 7;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TO    = 10;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] push = '0;
  logic [15:0] grant = '0;
  logic [15:0] pend_full;
  logic [15:0] req;
  logic        xfer_vld;
  logic [3:0]  xfer_port;
  logic        xfer_last;
  logic        err_grant;
  logic [15:0] starve;

  arb_req_agent_16 #(
    .BEAT_LEN(BL),
    .MAX_PEND(MAXP),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pend_full(pend_full),
    .req      (req),
    .grant    (grant),
    .xfer_vld (xfer_vld),
    .xfer_port(xfer_port),
    .xfer_last(xfer_last),
    .err_grant(err_grant),
    .starve   (starve)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Burst-level reference: tokens, requesting flag, beats left in burst
  int          m_pend [16];
  int          m_left [16];
  int          m_wait [16];
  logic [15:0] m_req;
  logic [15:0] m_starve;
  logic        m_vld;
  logic [3:0]  m_port;
  logic        m_last;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = 0;
      m_left[i] = BL;
      m_wait[i] = 0;
    end
    m_req    = '0;
    m_starve = '0;
    m_vld    = 1'b0;
    m_port   = '0;
    m_last   = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] p, input logic [15:0] g);
    bit legal;
    bit bt;
    bit lb;
    bit waiting;
    legal = ($countones(g) <= 1) && ((g & ~m_req) == 16'd0);
    m_err = !legal;
    m_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bt = legal && g[i];
      lb = 1'b0;
      waiting = m_req[i] && (m_left[i] == BL) && !g[i];
      if (TO_EN) begin
        if (bt) begin
          m_wait[i] = 0;
          m_starve[i] = 1'b0;
        end else if (waiting && m_wait[i] < 255) begin
          m_wait[i]++;
          if (m_wait[i] == TO)
            m_starve[i] = 1'b1;
        end
      end
      if (bt) begin
        m_left[i]--;
        lb = (m_left[i] == 0);
        m_vld = 1'b1;
        m_port = 4'(i);
        m_last = lb;
      end
      if (lb)
        m_pend[i] = m_pend[i] - 1 + int'(p[i]);
      else if (p[i] && m_pend[i] < MAXP)
        m_pend[i]++;
      if (lb) begin
        m_req[i] = 1'b0;
        m_left[i] = BL;
      end else if (!m_req[i]) begin
        m_req[i] = (m_pend[i] > 0);
      end
    end
  endtask

  task automatic cmp_model();
    logic [15:0] full;
    full = '0;
    for (int i = 0; i < 16; i++)
      full[i] = (m_pend[i] == MAXP);
    chk("req", 32'(req), 32'(m_req));
    chk("pend_full", 32'(pend_full), 32'(full));
    chk("xfer_vld", 32'(xfer_vld), 32'(m_vld));
    chk("xfer_port", 32'(xfer_port), 32'(m_port));
    chk("xfer_last", 32'(xfer_last), 32'(m_last));
    chk("err_grant", 32'(err_grant), 32'(m_err));
    chk("starve", 32'(starve), 32'(m_starve));
  endtask

  task automatic step(input logic [15:0] p, input logic [15:0] g);
    push  = p;
    grant = g;
    @(posedge clk);
    model_step(p, g);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push  = '0;
    grant = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] pick_req();
    int q[$];
    for (int i = 0; i < 16; i++)
      if (m_req[i]) q.push_back(i);
    if (q.size() == 0) return '0;
    return 16'(1) << q[$urandom_range(0, q.size() - 1)];
  endfunction

  // Well-behaved arbiter: grants one requesting port per cycle
  task automatic serve(input int n, input int port,
                       output int beats, output int lasts);
    beats = 0;
    lasts = 0;
    repeat (n) begin
      step('0, pick_req());
      if (xfer_vld && xfer_port == 4'(port)) begin
        beats++;
        if (xfer_last) lasts++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] push;
    logic [15:0] grant;
    logic [15:0] req;
    logic        vld;
    logic [3:0]  port;
    logic        last;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int b;
    int l;
    int cnt;
    logic [15:0] p;
    logic [15:0] g;
    int r;

    tbl[0] = '{16'h0008, 16'h0000, 16'h0008, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0008, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h0008, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0008, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0008, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0008, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0};

    do_reset();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_full", 32'(pend_full), 32'h0);
    chk("rst_vld", 32'(xfer_vld), 32'h0);
    chk("rst_port", 32'(xfer_port), 32'h0);
    chk("rst_last", 32'(xfer_last), 32'h0);
    chk("rst_err", 32'(err_grant), 32'h0);
    chk("rst_starve", 32'(starve), 32'h0);

    for (int k = 0; k < 8; k++) begin
      step(tbl[k].push, tbl[k].grant);
      chk($sformatf("tbl%0d_req", k), 32'(req), 32'(tbl[k].req));
      chk($sformatf("tbl%0d_vld", k), 32'(xfer_vld), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d_port", k), 32'(xfer_port), 32'(tbl[k].port));
      chk($sformatf("tbl%0d_last", k), 32'(xfer_last), 32'(tbl[k].last));
      chk($sformatf("tbl%0d_err", k), 32'(err_grant), 32'(tbl[k].err));
    end

    // Back-to-back tokens on port 0
    repeat (3) step(16'h0001, '0);
    serve(24, 0, b, l);
    chk("b2b_beats", 32'(b), 32'd12);
    chk("b2b_bursts", 32'(l), 32'd3);
    chk("b2b_req_end", 32'(req[0]), 32'h0);

    // Grant stall mid-burst on port 5
    cnt = 0;
    step(16'h0020, '0);
    for (int k = 0; k < 12; k++) begin
      g = (k >= 2 && k < 5) ? 16'h0 : (m_req & 16'h0020);
      step('0, g);
      if (k >= 2 && k < 5)
        chk("stall_novld", 32'(xfer_vld), 32'h0);
      if (xfer_vld && xfer_port == 4'd5) cnt++;
    end
    chk("stall_beats", 32'(cnt), 32'd4);

    // Illegal multi-hot grant, then grant to an idle port
    step(16'h0011, '0);
    step('0, 16'h0011);
    chk("ill_err", 32'(err_grant), 32'h1);
    chk("ill_novld", 32'(xfer_vld), 32'h0);
    chk("ill_req", 32'(req), 32'h0011);
    serve(16, 0, b, l);
    chk("ill_after0", 32'(b), 32'd4);
    step('0, 16'h0200);
    chk("idle_err", 32'(err_grant), 32'h1);
    step('0, '0);
    chk("idle_err_clr", 32'(err_grant), 32'h0);

    // Overflow on port 2
    for (int k = 0; k < 8; k++) begin
      step(16'h0004, '0);
      if (k == 6) chk("full_after7", 32'(pend_full[2]), 32'h1);
    end
    chk("full_after8", 32'(pend_full[2]), 32'h1);
    serve(45, 2, b, l);
    chk("ovf_bursts", 32'(l), 32'd7);
    chk("ovf_beats", 32'(b), 32'd28);

    // Starvation window on port 1
    step(16'h0002, '0);
    repeat (9) step('0, '0);
    chk("starve_pre", 32'(starve[1]), 32'h0);
    step('0, '0);
    chk("starve_set", 32'(starve[1]), 32'(TO_EN));
    step('0, 16'h0002);
    chk("starve_clr", 32'(starve[1]), 32'h0);
    serve(10, 1, b, l);

    // Reset mid-burst drops req asynchronously
    step(16'h0040, '0);
    step('0, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'h0);
    chk("arst_vld", 32'(xfer_vld), 32'h0);
    do_reset();
    step('0, '0);
    chk("arst_idle", 32'(req), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      p = 16'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       g = pick_req();
      else if (r == 7) g = '0;
      else if (r == 8) g = 16'(1) << $urandom_range(0, 15);
      else             g = 16'($urandom);
      step(p, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_req_agent_16.md
Name: arb_req_agent_16

Overview:
- Requester-side companion to the 16-port arbiter: owns the req[15:0] / grant[15:0] handshake from the client end.
- Each of 16 ports queues transaction tokens and raises req while any token is pending.
- On grant, the port streams a fixed-length burst, then drops req for one cycle so the arbiter re-arbitrates.
- Emits a serialized beat stream (port index, last flag) toward the shared datapath mux.

Parameters:
- BEAT_LEN, 4, beats per granted transaction (legal 1..16).
- MAX_PEND, 7, maximum queued tokens per port (legal 1..15).
- TIMEOUT, 255, starvation threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  16  per-port pulse: enqueue one transaction token.
- pend_full  out  16  per-port: pending count == MAX_PEND.
- req  out  16  per-port request to the arbiter.
- grant  in  16  one-hot grant from the arbiter, sampled on clk.
- xfer_vld  out  1  registered beat strobe.
- xfer_port  out  4  encoded port of the beat.
- xfer_last  out  1  beat is the final beat of its burst.
- err_grant  out  1  one-cycle pulse on an illegal grant.
- starve  out  16  per-port starvation flag (tied to 0 without the optional feature).

Behaviour:
- Reset (async assert, sync release): all ports IDLE; pending=0; beat counters=0; req=0; pend_full=0; xfer_vld=0; xfer_port=0; xfer_last=0; err_grant=0; starve=0.
- Per-port pending counter (4 bits):
  - push with count < MAX_PEND: +1.
  - push when full: dropped, no error.
  - Burst's last beat: -1.
  - push and last beat in the same cycle: count unchanged.
- Per-port FSM:
  - IDLE: req=0. Next cycle count > 0 -> REQ.
  - REQ: req=1. A cycle with grant[i]=1 is beat 0.
    - BEAT_LEN==1: go to REL.
    - Otherwise: go to XFER with beat_cnt=1.
  - XFER: req=1. Each cycle with grant[i]=1 is one beat; beat_cnt increments.
    - Beat with beat_cnt==BEAT_LEN-1 is last -> REL.
    - grant[i]=0 mid-burst: stall, no beat, state held, no error.
  - REL: req=0 for exactly one cycle; pending already decremented. Next state REQ if count > 0, else IDLE.
- req is a registered function of state (no combinational path grant->req).
- Beat output:
  - A beat at cycle N drives xfer_vld=1, xfer_port=i, xfer_last at cycle N+1. Fixed latency 1.
  - No beat: xfer_vld=0; xfer_port/xfer_last hold their previous values.
- Illegal grant, sampled each cycle:
  - grant multi-hot, or grant[i]=1 for a port in IDLE or REL.
  - Result: err_grant=1 next cycle; whole grant vector ignored that cycle (no beats, no state change).
  - grant=0 is legal.
- Reset mid-burst: burst abandoned; pending tokens lost; req drops immediately (async).
- Counter widths: beat_cnt 4 bits. BEAT_LEN=16 wraps correctly because last is detected by compare with BEAT_LEN-1.

Optional Feature:
- Macro ARB_REQ_TIMEOUT_EN.
- Defined:
  - Per-port 8-bit wait counter runs while the port is in REQ with grant[i]=0; it saturates.
  - starve[i] is set the cycle the counter reaches TIMEOUT and stays set until the port's first beat.
  - Counter and flag clear on beat or reset.
- Undefined: no counters; starve=16'h0000.

Test Plan:
- Single port, no contention: push[3] once; arbiter grants port 3 for 4 cycles -> req[3]=1 one cycle after push; xfer_vld for 4 cycles with xfer_port=3; xfer_last on the 4th; req[3]=0 for one REL cycle, then IDLE.
- Back-to-back tokens: push[0] three times, grant held continuously -> 12 beats in 3 bursts separated by single req-low gaps; pending ends at 0.
- Grant stall: mid-burst grant[5] deasserts for 3 cycles -> no xfer_vld during the gap; burst resumes at the same beat index; exactly 4 beats total.
- Illegal grant: grant=16'h0011 while ports 0 and 4 are in REQ -> err_grant pulse next cycle; no beats; both stay in REQ. Separately, grant[9] with port 9 IDLE -> err_grant=1.
- Overflow: 8 pushes to port 2 with no grant -> pend_full[2]=1 after the 7th; 8th dropped; port then completes exactly 7 bursts.
- With ARB_REQ_TIMEOUT_EN, TIMEOUT=10: port 1 in REQ, grant withheld 10 cycles -> starve[1]=1; clears after its first beat. Without the macro -> starve stays 0.
